// File: rtl/rle_stream_encoder.sv
// rtl/rle_stream_encoder.sv - parametrised run-length encoder with valid/ready streams
module rle_stream_encoder #(
  parameter int DW       = 32,
  parameter int CW       = 8,
  parameter int CNT_BIAS = 0
) (
  input  logic          clock,
  input  logic          sysres,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  // Longest run one pair can describe; the bias trades a zero count for one extra length step.
  localparam logic [CW:0] MAXRUN = (CW+1)'((1 << CW) - 1 + CNT_BIAS);
  localparam logic [CW:0] BIAS_V = (CW+1)'(CNT_BIAS);
  localparam logic [CW:0] ONE    = (CW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cur_pix_q, cur_pix_d;
  logic [CW:0]   run_len_q, run_len_d;
  logic [DW-1:0] out_data_q;
  logic [CW-1:0] out_count_q;
  logic          out_last_q, out_valid_q;

  logic          emit;
  logic [DW-1:0] emit_data;
  logic [CW:0]   emit_len;
  logic          emit_last;

  logic slot_free, accept, match, room;

  assign slot_free = !out_valid_q || out_ready;
  // Held low during reset so nothing is taken before the encoder is out of reset.
  assign in_ready  = sysres && slot_free && (state_q != FLUSH);
  assign accept    = in_valid && in_ready;
  assign match     = (in_data == cur_pix_q);
  assign room      = (run_len_q < MAXRUN);

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  // State register.
  always_ff @(posedge clock or negedge sysres) begin
    if (!sysres) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: a closing beat that also has to emit the previous run leaves a one-pixel run for FLUSH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) state_d = RUN;
      end
      RUN: begin
        if (accept && in_last) state_d = (match && room) ? IDLE : FLUSH;
      end
      FLUSH: begin
        if (slot_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping and selection of the pair to load into the output slot.
  always_comb begin
    cur_pix_d = cur_pix_q;
    run_len_d = run_len_q;
    emit      = 1'b0;
    emit_data = cur_pix_q;
    emit_len  = run_len_q;
    emit_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_pix_d = in_data;
          run_len_d = ONE;
          if (in_last) begin
            emit      = 1'b1;
            emit_data = in_data;
            emit_len  = ONE;
            emit_last = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (match && room) begin
            run_len_d = run_len_q + ONE;
            if (in_last) begin
              emit      = 1'b1;
              emit_len  = run_len_q + ONE;
              emit_last = 1'b1;
            end
          end else if (match) begin
            emit      = 1'b1;
            emit_len  = MAXRUN;
            run_len_d = ONE;
          end else begin
            emit      = 1'b1;
            emit_len  = run_len_q;
            cur_pix_d = in_data;
            run_len_d = ONE;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_len  = ONE;
          emit_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Open-run registers.
  always_ff @(posedge clock or negedge sysres) begin
    if (!sysres) begin
      cur_pix_q <= '0;
      run_len_q <= '0;
    end else begin
      cur_pix_q <= cur_pix_d;
      run_len_q <= run_len_d;
    end
  end

  // Single-entry output slot: loads on emit, clears once drained with nothing new.
  always_ff @(posedge clock or negedge sysres) begin
    if (!sysres) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= emit_data;
      out_count_q <= CW'(emit_len - BIAS_V);
      out_last_q  <= emit_last;
    end else if (slot_free) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rle_stream_encoder.sv
// tb/tb_rle_stream_encoder.sv - randomized and directed bench for rle_stream_encoder
module tb_rle_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_valid;
  wire  [2:0]  in_ready, out_valid, out_last;
  wire  [31:0] od0, od1, od2;
  wire  [7:0]  oc0;
  wire  [1:0]  oc1, oc2;
  logic        out_ready;
  logic        bp_en;

  int vectors = 0;
  int miscompares = 0;

  logic [40:0] obs_q[3][$];
  logic [40:0] exp_q[3][$];

  always #5 clk = ~clk;

  rle_stream_encoder #(.DW(32), .CW(8), .CNT_BIAS(0)) u0 (
    .clock(clk), .sysres(rst_n), .in_data(in_data), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_last(in_last), .out_data(od0), .out_count(oc0), .out_last(out_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready));
  rle_stream_encoder #(.DW(32), .CW(2), .CNT_BIAS(0)) u1 (
    .clock(clk), .sysres(rst_n), .in_data(in_data), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_last(in_last), .out_data(od1), .out_count(oc1), .out_last(out_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready));
  rle_stream_encoder #(.DW(32), .CW(2), .CNT_BIAS(1)) u2 (
    .clock(clk), .sysres(rst_n), .in_data(in_data), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_last(in_last), .out_data(od2), .out_count(oc2), .out_last(out_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready));

  function automatic logic [40:0] cur_pair(int k);
    case (k)
      0:       return {out_last[0], oc0, od0};
      1:       return {out_last[1], 6'd0, oc1, od1};
      default: return {out_last[2], 6'd0, oc2, od2};
    endcase
  endfunction

  function automatic logic [40:0] mk(logic l, int c, logic [31:0] d);
    return {l, 8'(c), d};
  endfunction

  // Record every pair on the cycle it is handed downstream.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_ready === 1'b1)
      for (int k = 0; k < 3; k++)
        if (out_valid[k] === 1'b1) obs_q[k].push_back(cur_pair(k));
  end

  // Random downstream backpressure.
  always @(posedge clk) begin
    if (bp_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference: split the frame into runs of equal pixels, cut each into MAXRUN-sized chunks.
  task automatic model_frame(int k, input logic [31:0] pix[$]);
    int maxrun, bias, mask, i, j, len, c;
    maxrun = (k == 0) ? 255 : ((k == 1) ? 3 : 4);
    bias   = (k == 2) ? 1 : 0;
    mask   = (k == 0) ? 255 : 3;
    i = 0;
    while (i < pix.size()) begin
      j = i;
      while (j < pix.size() && pix[j] == pix[i]) j++;
      len = j - i;
      while (len > 0) begin
        c = (len > maxrun) ? maxrun : len;
        len -= c;
        exp_q[k].push_back(mk((j == pix.size()) && (len == 0), (c - bias) & mask, pix[i]));
      end
      i = j;
    end
  endtask

  task automatic drive_beat(int k, logic [31:0] d, logic l);
    int t = 0;
    in_data = d;
    in_last = l;
    in_valid[k] = 1'b1;
    @(negedge clk);
    while (in_ready[k] !== 1'b1 && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (in_ready[k] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout dut=%0d in_ready=%b required=1", k, in_ready[k]);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic settle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if (out_valid !== 3'b000 || in_ready !== 3'b000 || out_last !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags valid=%b ready=%b last=%b required=000", out_valid, in_ready, out_last);
    end
    vectors++;
    if (od0 !== 32'd0 || oc0 !== 8'd0 || oc1 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_data data=%h count=%h required=0", od0, oc0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle(1);
    vectors++;
    if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release ready=%b valid=%b required ready=111 valid=000", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    logic [31:0] a, b;
    logic [31:0] pix[5];
    logic [40:0] want;
    a = 32'hA0A0_0001;
    b = 32'hB0B0_0002;
    pix = '{a, a, a, b, b};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = pix[i];
      in_last = (i == 4);
      in_valid[0] = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_ready beat=%0d got=%b required=1", i, in_ready[0]);
      end
      @(posedge clk);
      #1;
      want = (i == 3) ? mk(1'b0, 3, a) : mk(1'b1, 2, b);
      vectors++;
      if (out_valid[0] !== (i >= 3)) begin
        miscompares++;
        $display("FAIL basic_valid beat=%0d got=%b required=%b", i, out_valid[0], (i >= 3));
      end else if (i >= 3) begin
        vectors++;
        if (cur_pair(0) !== want) begin
          miscompares++;
          $display("FAIL basic_pair beat=%0d got=%h required=%h", i, cur_pair(0), want);
        end
      end
    end
    in_valid[0] = 1'b0;
    in_last = 1'b0;
    settle(1);
    vectors++;
    if (out_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain got=%b required=0", out_valid[0]);
    end
  endtask

  task automatic test_split;
    logic [31:0] a;
    a = 32'h1234_5678;
    out_ready = 1'b1;
    obs_q[1].delete();
    obs_q[2].delete();
    for (int k = 1; k < 3; k++)
      for (int i = 0; i < 5; i++) drive_beat(k, a, i == 4);
    settle(3);
    vectors++;
    if (obs_q[1].size() != 2 || obs_q[2].size() != 2) begin
      miscompares++;
      $display("FAIL split_count got=%0d,%0d required=2,2", obs_q[1].size(), obs_q[2].size());
    end else begin
      vectors++;
      if (obs_q[1][0] !== mk(1'b0, 3, a) || obs_q[1][1] !== mk(1'b1, 2, a)) begin
        miscompares++;
        $display("FAIL split_bias0 got=%h,%h required=%h,%h", obs_q[1][0], obs_q[1][1], mk(1'b0, 3, a), mk(1'b1, 2, a));
      end
      vectors++;
      if (obs_q[2][0] !== mk(1'b0, 3, a) || obs_q[2][1] !== mk(1'b1, 0, a)) begin
        miscompares++;
        $display("FAIL split_bias1 got=%h,%h required=%h,%h", obs_q[2][0], obs_q[2][1], mk(1'b0, 3, a), mk(1'b1, 0, a));
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] a;
    a = 32'hCAFE_0003;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = a;
      in_last = (i == 3);
      in_valid[1] = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL flush_ready_pre beat=%0d got=%b required=1", i, in_ready[1]);
      end
      @(posedge clk);
      #1;
    end
    in_valid[1] = 1'b0;
    in_last = 1'b0;
    vectors++;
    if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || cur_pair(1) !== mk(1'b0, 3, a)) begin
      miscompares++;
      $display("FAIL flush_first ready=%b pair=%h required ready=0 pair=%h", in_ready[1], cur_pair(1), mk(1'b0, 3, a));
    end
    settle(1);
    vectors++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b1 || cur_pair(1) !== mk(1'b1, 1, a)) begin
      miscompares++;
      $display("FAIL flush_second ready=%b pair=%h required ready=1 pair=%h", in_ready[1], cur_pair(1), mk(1'b1, 1, a));
    end
    settle(1);
    vectors++;
    if (out_valid[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drain got=%b required=0", out_valid[1]);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b, c;
    a = 32'h0000_00AA;
    b = 32'h0000_00BB;
    c = 32'h0000_00CC;
    out_ready = 1'b0;
    obs_q[0].delete();
    drive_beat(0, a, 1'b0);
    drive_beat(0, b, 1'b0);
    in_data = c;
    in_last = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || cur_pair(0) !== mk(1'b0, 1, a)) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d ready=%b valid=%b pair=%h required ready=0 valid=1 pair=%h",
                 i, in_ready[0], out_valid[0], cur_pair(0), mk(1'b0, 1, a));
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got=%b required=1", in_ready[0]);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_last = 1'b0;
    settle(4);
    vectors++;
    if (obs_q[0].size() != 3) begin
      miscompares++;
      $display("FAIL bp_count got=%0d required=3", obs_q[0].size());
    end else begin
      vectors++;
      if (obs_q[0][0] !== mk(1'b0, 1, a) || obs_q[0][1] !== mk(1'b0, 1, b) || obs_q[0][2] !== mk(1'b1, 1, c)) begin
        miscompares++;
        $display("FAIL bp_pairs got=%h,%h,%h required=%h,%h,%h", obs_q[0][0], obs_q[0][1], obs_q[0][2],
                 mk(1'b0, 1, a), mk(1'b0, 1, b), mk(1'b1, 1, c));
      end
    end
  endtask

  task automatic test_single;
    logic [31:0] x, y;
    x = 32'hDEAD_BEEF;
    y = 32'h0BAD_F00D;
    out_ready = 1'b1;
    obs_q[0].delete();
    drive_beat(0, x, 1'b1);
    vectors++;
    if (out_valid[0] !== 1'b1 || cur_pair(0) !== mk(1'b1, 1, x)) begin
      miscompares++;
      $display("FAIL single_pair valid=%b got=%h required=%h", out_valid[0], cur_pair(0), mk(1'b1, 1, x));
    end
    drive_beat(0, y, 1'b0);
    drive_beat(0, y, 1'b1);
    settle(2);
    vectors++;
    if (obs_q[0].size() != 2 || obs_q[0][0] !== mk(1'b1, 1, x) || obs_q[0][1] !== mk(1'b1, 2, y)) begin
      miscompares++;
      $display("FAIL single_next size=%0d required 2 pairs %h,%h", obs_q[0].size(), mk(1'b1, 1, x), mk(1'b1, 2, y));
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a, b, c;
    a = 32'h0000_0A0A;
    b = 32'h0000_0B0B;
    c = 32'h0000_0C0C;
    out_ready = 1'b0;
    drive_beat(0, a, 1'b0);
    drive_beat(0, a, 1'b0);
    drive_beat(0, b, 1'b0);
    vectors++;
    if (out_valid[0] !== 1'b1 || cur_pair(0) !== mk(1'b0, 2, a)) begin
      miscompares++;
      $display("FAIL rst_pending got=%h required=%h", cur_pair(0), mk(1'b0, 2, a));
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async valid=%b ready=%b required 0,0", out_valid[0], in_ready[0]);
    end
    obs_q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    settle(1);
    out_ready = 1'b1;
    drive_beat(0, c, 1'b1);
    settle(3);
    vectors++;
    if (obs_q[0].size() != 1 || obs_q[0][0] !== mk(1'b1, 1, c)) begin
      miscompares++;
      $display("FAIL rst_after size=%0d required 1 pair %h", obs_q[0].size(), mk(1'b1, 1, c));
    end
  endtask

  task automatic test_random;
    logic [31:0] alpha[3];
    logic [31:0] pix[$];
    logic [31:0] v;
    int len, t;
    bp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      obs_q[k].delete();
      exp_q[k].delete();
      for (int a = 0; a < 3; a++) alpha[a] = $urandom;
      for (int f = 0; f < 8; f++) begin
        pix.delete();
        len = (k == 0 && f == 0) ? 260 : $urandom_range(1, 14);
        v = alpha[$urandom_range(0, 2)];
        for (int i = 0; i < len; i++) begin
          if (k != 0 || f != 0)
            if ($urandom_range(0, 2) == 0) v = alpha[$urandom_range(0, 2)];
          pix.push_back(v);
        end
        model_frame(k, pix);
        for (int i = 0; i < pix.size(); i++) begin
          drive_beat(k, pix[i], i == pix.size() - 1);
          if ($urandom_range(0, 3) == 0) settle(1);
        end
      end
      t = 0;
      while (obs_q[k].size() < exp_q[k].size() && t < 3000) begin
        @(posedge clk);
        t++;
      end
      settle(3);
      vectors++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        miscompares++;
        $display("FAIL rand_count dut=%0d got=%0d required=%0d", k, obs_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
        vectors++;
        if (obs_q[k][i] !== exp_q[k][i]) begin
          miscompares++;
          $display("FAIL rand_pair dut=%0d idx=%0d got=%h required=%h", k, i, obs_q[k][i], exp_q[k][i]);
        end
      end
    end
    bp_en = 1'b0;
    settle(1);
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_valid = 3'b000;
    out_ready = 1'b0;
    bp_en = 1'b0;
    test_reset;
    test_basic;
    test_split;
    test_flush;
    test_backpressure;
    test_single;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
